// File: rtl/fc_layer_sched.sv
// fc_layer_sched: walks OUT_NUM neurons through one shared pipelined fc engine, credit-limits
// issue against a small result FIFO and streams {idx,data} downstream. Macro: FC_SCHED_RELU_EN.
module fc_layer_sched #(
  parameter int OUT_NUM    = 84,
  parameter int OUT_WIDTH  = 16,
  parameter int ENG_LAT    = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(OUT_NUM)-1:0] rom_addr,
  output logic                       rom_en,
  output logic                       eng_go,
  input  logic                       eng_valid,
  input  logic [OUT_WIDTH-1:0]       eng_out,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [OUT_WIDTH-1:0]       m_data,
  output logic [$clog2(OUT_NUM)-1:0] m_idx,
  output logic                       m_last
);
  localparam int AW = $clog2(OUT_NUM);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(OUT_NUM - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                    state, state_nxt;
  logic [AW-1:0]             issue_idx, res_idx;
  logic [CW-1:0]             in_flight, fifo_count;
  logic [CW:0]               outstanding;
  logic [PW-1:0]             wr_ptr, rd_ptr;
  logic [AW+OUT_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
  logic [AW+OUT_WIDTH-1:0]   rd_word;
  logic [OUT_WIDTH-1:0]      push_data;
  logic                      push, pop;

  // The rom_en of last cycle is already committed to the engine, so it holds a credit too.
  assign outstanding = {1'b0, in_flight} + {1'b0, fifo_count} + (CW+1)'(eng_go);

  // Stale results after a mid-operation reset arrive with nothing in flight and are dropped.
  assign push = eng_valid && (in_flight != '0);
  assign pop  = m_valid && m_ready;

`ifdef FC_SCHED_RELU_EN
  assign push_data = eng_out[OUT_WIDTH-1] ? '0 : eng_out;
`else
  assign push_data = eng_out;
`endif

  assign rd_word  = fifo_mem[rd_ptr];
  assign m_valid  = (fifo_count != '0);
  assign m_data   = m_valid ? rd_word[OUT_WIDTH-1:0] : '0;
  assign m_idx    = m_valid ? rd_word[AW+OUT_WIDTH-1:OUT_WIDTH] : '0;
  assign m_last   = m_valid && (rd_word[AW+OUT_WIDTH-1:OUT_WIDTH] == LAST_IDX);
  assign busy     = (state != IDLE);
  assign rom_addr = issue_idx;

  always_comb begin
    state_nxt = state;
    rom_en    = 1'b0;
    done      = 1'b0;
    unique case (state)
      IDLE:  if (start) state_nxt = ISSUE;
      ISSUE: begin
        if (outstanding < {1'b0, DEPTH_C}) begin
          rom_en = 1'b1;
          if (issue_idx == LAST_IDX) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          done      = 1'b1;
          state_nxt = start ? ISSUE : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      eng_go     <= 1'b0;
      issue_idx  <= '0;
      res_idx    <= '0;
      in_flight  <= '0;
      fifo_count <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
    end else begin
      state  <= state_nxt;
      eng_go <= rom_en;
      if (rom_en) issue_idx <= (issue_idx == LAST_IDX) ? '0 : issue_idx + AW'(1);
      if (push)   res_idx   <= (res_idx == LAST_IDX) ? '0 : res_idx + AW'(1);
      unique case ({eng_go, push})
        2'b10:   in_flight <= in_flight + CW'(1);
        2'b01:   in_flight <= in_flight - CW'(1);
        default: ;
      endcase
      unique case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: ;
      endcase
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {res_idx, push_data};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(push && !pop && fifo_count == DEPTH_C));
      assert (fifo_count <= DEPTH_C);
      assert (int'(in_flight) <= ENG_LAT);
    end
  end
endmodule

// File: tb/tb_fc_layer_sched.sv
// tb_fc_layer_sched: drives fc_layer_sched with a ROM/engine model and checks the result stream
// against an expected per-pass neuron sequence.
module tb_fc_layer_sched;
  localparam int OUT_NUM = 84, OUT_WIDTH = 16, ENG_LAT = 10, FIFO_DEPTH = 8;
  localparam int AW = $clog2(OUT_NUM);

  logic clk = 1'b0, rst, start, eng_valid, m_ready;
  logic [OUT_WIDTH-1:0] eng_out, m_data;
  logic busy, done, rom_en, eng_go, m_valid, m_last;
  logic [AW-1:0] rom_addr, m_idx;

  always #5 clk = ~clk;

  fc_layer_sched #(.OUT_NUM(OUT_NUM), .OUT_WIDTH(OUT_WIDTH), .ENG_LAT(ENG_LAT),
                   .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rom_addr(rom_addr), .rom_en(rom_en), .eng_go(eng_go), .eng_valid(eng_valid),
    .eng_out(eng_out), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_idx(m_idx), .m_last(m_last));

  typedef struct { int due; int val; } eop_t;

  int   n_pass = 0, n_total = 0, cyc = 0;
  int   vals [OUT_NUM];
  eop_t eq [$];
  int   rom_q = 0;
  bit   pass_on = 0, seen_go, seen_mv, ready_hi, hold_v = 0;
  int   exp_idx, gos = 0, accepted, s_cyc, last_go, passes = 0;
  logic [AW-1:0] hold_idx;
  logic [OUT_WIDTH-1:0] hold_data, d3;

  function automatic logic [OUT_WIDTH-1:0] exp_data(input int v);
`ifdef FC_SCHED_RELU_EN
    return (v < 0) ? '0 : OUT_WIDTH'(v);
`else
    return OUT_WIDTH'(v);
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_reset();
    chk("rst_busy", busy, 0);     chk("rst_done", done, 0);     chk("rst_rom_en", rom_en, 0);
    chk("rst_eng_go", eng_go, 0); chk("rst_m_valid", m_valid, 0); chk("rst_rom_addr", rom_addr, 0);
    chk("rst_m_idx", m_idx, 0);   chk("rst_m_data", m_data, 0); chk("rst_m_last", m_last, 0);
  endtask

  // One clock cycle: drive inputs at negedge, sample, advance the reference model.
  task automatic step(input bit s_in, input bit r_in, input bit rst_in, input bit sod);
    bit   beat;
    eop_t e;
    @(negedge clk);
    cyc++;
    rst = rst_in; start = s_in; m_ready = r_in;
    eng_valid = 1'b0; eng_out = '0;
    if (eq.size() > 0 && eq[0].due == cyc) begin
      eng_valid = 1'b1;
      eng_out   = OUT_WIDTH'(eq[0].val);
      void'(eq.pop_front());
    end
    #1;
    if (sod && m_valid && m_last && m_ready) begin start = 1'b1; #1; end
    if (eng_go === 1'b1) begin e.due = cyc + ENG_LAT; e.val = vals[rom_q]; eq.push_back(e); end
    if (rom_en === 1'b1) rom_q = int'(rom_addr);
    if (rst_in) begin pass_on = 0; hold_v = 0; return; end

    chk("busy", busy, pass_on);
    if (!pass_on) begin
      chk("idle_eng_go", eng_go, 0);
      chk("idle_m_valid", m_valid, 0);
    end else if (eng_go) begin
      gos++; last_go = cyc;
      if (!seen_go) begin chk("first_go_lat", cyc - s_cyc, 2); seen_go = 1; end
    end
    if (pass_on && m_valid && !seen_mv) begin
      chk("first_mvalid_lat", cyc - s_cyc, ENG_LAT + 3); seen_mv = 1;
    end
    if (hold_v) begin
      chk("hold_valid", m_valid, 1); chk("hold_idx", m_idx, hold_idx); chk("hold_data", m_data, hold_data);
    end
    beat = m_valid && m_ready;
    chk("done", done, beat && pass_on && exp_idx == OUT_NUM - 1);
    if (pass_on) begin
      ready_hi &= m_ready;
      chk("credit", (gos - accepted) <= FIFO_DEPTH, 1);
    end
    if (beat && pass_on) begin
      chk("m_idx", m_idx, exp_idx);
      chk("m_data", m_data, exp_data(vals[exp_idx]));
      chk("m_last", m_last, exp_idx == OUT_NUM - 1);
      if (exp_idx == 3) d3 = m_data;
      exp_idx++; accepted++;
      if (exp_idx == OUT_NUM) begin
        chk("gos_per_pass", gos, OUT_NUM);
        if (ready_hi) chk("done_lat", cyc - last_go, ENG_LAT + 1);
        pass_on = 0; passes++;
      end
    end
    hold_v = m_valid && !m_ready; hold_idx = m_idx; hold_data = m_data;
    if (start && (!busy || done)) begin
      pass_on = 1; s_cyc = cyc; exp_idx = 0; gos = 0; accepted = 0;
      seen_go = 0; seen_mv = 0; ready_hi = 1;
    end
  endtask

  task automatic run(input bit rnd_ready);
    for (int k = 0; k < 4000 && pass_on; k++)
      step(0, rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1, 0, 0);
    chk("pass_timeout", pass_on, 0);
  endtask

  task automatic rand_vals();
    for (int i = 0; i < OUT_NUM; i++) vals[i] = int'($urandom_range(0, 4000)) - 2000;
  endtask

  initial begin
    bit ign, s;
    int p0;
    rst = 1'b1; start = 1'b0; m_ready = 1'b0; eng_valid = 1'b0; eng_out = '0;
    for (int i = 0; i < OUT_NUM; i++) vals[i] = 0;

    // reset with a start strobe inside it
    step(0, 0, 1, 0); step(1, 0, 1, 0); step(0, 0, 1, 0);
    step(0, 1, 0, 0); check_reset();
    step(0, 1, 0, 0); check_reset();

    // full pass, ready tied high, engine returns idx*4-100
    for (int i = 0; i < OUT_NUM; i++) vals[i] = i * 4 - 100;
    step(1, 1, 0, 0); run(0);
    step(0, 1, 0, 0); check_reset();

    // downstream stalled: issue must stop at the credit limit
    rand_vals();
    step(1, 0, 0, 0);
    repeat (40) step(0, 0, 0, 0);
    chk("stall_gos", gos, FIFO_DEPTH);
    chk("stall_rom_en", rom_en, 0);
    run(1);

    // negative value at idx 3, random backpressure
    rand_vals(); vals[3] = -5; d3 = 16'h1234;
    step(1, 1, 0, 0); run(1);
`ifdef FC_SCHED_RELU_EN
    chk("relu_idx3", d3, 16'h0000);
`else
    chk("relu_idx3", d3, 16'hFFFB);
`endif

    // start while busy is ignored; start on the done cycle chains a new pass
    rand_vals(); ign = 0; p0 = passes;
    step(1, 1, 0, 0);
    for (int k = 0; k < 8000 && pass_on; k++) begin
      s = 0;
      if (gos == 40 && !ign) begin s = 1; ign = 1; end
      step(s, $urandom_range(0, 3) != 0, 0, passes == p0);
    end
    chk("pass_timeout", pass_on, 0);
    chk("ignored_start_hit", ign, 1);
    chk("chained_passes", passes - p0, 2);

    // reset mid-operation with results still in the engine
    rand_vals();
    step(1, 1, 0, 0);
    for (int k = 0; k < 2000 && gos < 20; k++) step(0, 1, 0, 0);
    chk("stale_pending", eq.size() > 0, 1);
    step(0, 1, 1, 0);
    step(0, 1, 0, 0); check_reset();
    repeat (ENG_LAT + 2) step(0, 1, 0, 0);
    chk("stale_drained", eq.size(), 0);
    rand_vals();
    step(1, 1, 0, 0); run(1);
    step(0, 1, 0, 0); check_reset();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
